// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and default sizing for the data memory slice
package dmem_pkg;

    localparam int DMEM_DATA_W  = 8;
    localparam int DMEM_ADDR_W  = 8;
    localparam int DMEM_DEPTH   = 256;
    localparam int DMEM_LATENCY = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x DATA_W storage, sync write, registered sync read, sync clear
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            // rdata only moves on a completed read, so it holds across writes
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - fixed-latency load/store responder; DMEM_ERR_EN adds ERR and rejects READ&WRITE
module data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
`ifdef DMEM_ERR_EN
    output logic              ERR,
`endif
    output logic              BUSYWAIT
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t            state;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              finish;

`ifdef DMEM_ERR_EN
    logic err_q;

    assign accept = (state == IDLE) && (READ ^ WRITE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && READ && WRITE) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign accept = (state == IDLE) && (READ || WRITE);
`endif

    assign BUSYWAIT = accept || (state == BUSY);
    assign finish   = (state == BUSY) && (cnt == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // WRITE wins when both are high (only reachable without DMEM_ERR_EN)
                        op_q    <= WRITE ? OP_WRITE : OP_READ;
                        addr_q  <= ADDRESS[IDX_W-1:0];
                        wdata_q <= WRITEDATA;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (finish && (op_q == OP_WRITE)),
        .re    (finish && (op_q == OP_READ)),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (READDATA)
    );

endmodule
